// File: rtl/seq_shift_add_mult_pkg.sv
// ---------------------------------------------------------------------------
// seq_shift_add_mult_pkg
// Shared definitions for the sequential shift-and-add multiplier:
//   - raw state encodings and the enum built on them
//   - helper that sizes the iteration counter for a given operand width
// No ports; imported by seq_shift_add_mult.
// ---------------------------------------------------------------------------
package seq_shift_add_mult_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

   // The counter has to be able to represent every value from 0 to WIDTH.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/seq_shift_add_mult_rca_adder.sv
// ---------------------------------------------------------------------------
// full_adder / rca_adder
// Ripple-carry adder built from single-bit full-adder cells.
//   full_adder ports: a, b, c_in -> s, c_out   (one bit each)
//   rca_adder  ports: a[WIDTH-1:0], b[WIDTH-1:0], c_in -> s[WIDTH-1:0], c_out
// The multiplier reuses one rca_adder every cycle for its partial-product add.
// ---------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic s,
   output logic c_out
);

   // Classic sum/carry equations for one bit position.
   assign s     = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

module rca_adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] s,
   output logic             c_out
);

   logic [WIDTH:0] carry;

   assign carry[0] = c_in;

   // Each cell consumes the carry of the bit below it; the top carry leaves the adder.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .c_in (carry[i]),
         .s    (s[i]),
         .c_out(carry[i+1])
      );
   end

   assign c_out = carry[WIDTH];

endmodule

// File: rtl/seq_shift_add_mult.sv
// ---------------------------------------------------------------------------
// seq_shift_add_mult
// Sequential unsigned shift-and-add multiplier. Operands are captured on an
// accepted start, the product is built over WIDTH iterations using a single
// ripple-carry adder, then presented with a one-cycle done pulse.
// Ports:
//   clk      system clock, rising edge
//   rst_n    synchronous active-low reset
//   start    begin a multiply (only looked at while idle)
//   a, b     multiplicand / multiplier, WIDTH bits each
//   busy     high whenever the machine is not idle
//   done     one-cycle pulse when product has just been updated
//   product  2*WIDTH-bit result, held until the next completion or reset
// ---------------------------------------------------------------------------
module seq_shift_add_mult
   import seq_shift_add_mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int              CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   state_t             state;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;

   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   sum;
   logic               carry_out;
   logic [2*WIDTH-1:0] acc_next;

   // The low bit of the accumulator is the multiplier bit being consumed this
   // iteration; it decides whether the multiplicand joins the upper half.
   assign addend = acc[0] ? mcand : '0;

   rca_adder #(.WIDTH(WIDTH)) u_adder (
      .a    (acc[2*WIDTH-1:WIDTH]),
      .b    (addend),
      .c_in (1'b0),
      .s    (sum),
      .c_out(carry_out)
   );

   // The carry becomes the new MSB as everything shifts right by one, so the
   // 2W+1-bit intermediate sum never loses information.
   assign acc_next = {carry_out, sum, acc[WIDTH-1:1]};

   // Status flags come straight from the state register, so they cannot glitch
   // with the inputs.
   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // Main controller: captures operands, runs exactly WIDTH shift/add steps,
   // latches the result on the last step, then spends one cycle in DONE.
   // Reset wins over everything, including a multiply in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         mcand   <= '0;
         acc     <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand <= a;
                  acc   <= {{WIDTH{1'b0}}, b};
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               acc <= acc_next;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  product <= acc_next;
                  state   <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// ---------------------------------------------------------------------------
// tb_seq_shift_add_mult
// Self-checking bench for seq_shift_add_mult (WIDTH=8): directed vector table,
// random operands against a plain-arithmetic model, and hand-written
// sequences for reset, start-while-busy and abort.
// ---------------------------------------------------------------------------
module tb_seq_shift_add_mult;

   localparam int WIDTH = 8;
   localparam int LAT   = WIDTH + 1;
   localparam int LIMIT = 40;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] product;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [WIDTH-1:0]   va;
      logic [WIDTH-1:0]   vb;
      logic [2*WIDTH-1:0] expProduct;
   } vector_t;

   vector_t vectors[5];

   seq_shift_add_mult #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .product(product)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against what the bench expects.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Step one rising edge and settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Plain arithmetic reference for an unsigned multiply.
   function automatic logic [2*WIDTH-1:0] modelProduct(input logic [WIDTH-1:0] x,
                                                       input logic [WIDTH-1:0] y);
      return (2*WIDTH)'(int'(x) * int'(y));
   endfunction

   // Pulse start for one cycle with the given operands, scramble the operands
   // right after they are captured, and wait (bounded) for done.
   // lat is the number of edges from driving start until done is seen.
   task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                output int lat, output logic busyAfter,
                                output logic [2*WIDTH-1:0] prod);
      a     = x;
      b     = y;
      start = 1'b1;
      tick();
      start     = 1'b0;
      a         = WIDTH'($urandom);
      b         = WIDTH'($urandom);
      busyAfter = busy;
      lat       = 1;
      while (!done && lat < LIMIT) begin
         tick();
         lat++;
      end
      prod = product;
   endtask

   // A full multiply with latency, result, pulse width and hold checks.
   task automatic runMult(input string name, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input logic [2*WIDTH-1:0] expected);
      int                 lat;
      logic               busyAfter;
      logic [2*WIDTH-1:0] prod;
      applyStimulus(x, y, lat, busyAfter, prod);
      checkOutput({name, " latency"}, lat, LAT);
      checkOutput({name, " busy"}, 32'(busyAfter), 32'd1);
      checkOutput({name, " product"}, 32'(prod), 32'(expected));
      tick();
      checkOutput({name, " done width"}, 32'(done), 32'd0);
      checkOutput({name, " hold"}, 32'(product), 32'(expected));
   endtask

   initial begin
      int                 lat;
      int                 doneSeen;
      logic [WIDTH-1:0]   rx;
      logic [WIDTH-1:0]   ry;

      vectors[0] = '{8'd13,  8'd11,  16'h008F};
      vectors[1] = '{8'hFF,  8'hFF,  16'hFE01};
      vectors[2] = '{8'h80,  8'hFF,  16'h7F80};
      vectors[3] = '{8'd0,   8'd200, 16'h0000};
      vectors[4] = '{8'd200, 8'd0,   16'h0000};

      // Reset held with a start request pending must not launch anything.
      rst_n = 1'b0;
      start = 1'b1;
      a     = 8'hFF;
      b     = 8'hFF;
      tick();
      tick();
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset product", 32'(product), 32'd0);
      start = 1'b0;
      rst_n = 1'b1;
      tick();
      checkOutput("post-reset idle", 32'(busy), 32'd0);

      // Directed table.
      for (int i = 0; i < 5; i++) begin
         runMult($sformatf("vec%0d", i), vectors[i].va, vectors[i].vb, vectors[i].expProduct);
      end

      // Random operands against the arithmetic model.
      for (int i = 0; i < 20; i++) begin
         rx = WIDTH'($urandom);
         ry = WIDTH'($urandom);
         runMult($sformatf("rand%0d", i), rx, ry, modelProduct(rx, ry));
      end

      // start held high throughout: second request is only taken once idle again.
      a     = 8'd13;
      b     = 8'd11;
      start = 1'b1;
      tick();
      a   = 8'd3;
      b   = 8'd3;
      lat = 1;
      while (!done && lat < LIMIT) begin
         tick();
         lat++;
      end
      checkOutput("held latency", lat, LAT);
      checkOutput("held product", 32'(product), 32'd143);
      tick();
      checkOutput("held idle gap", 32'(busy), 32'd0);
      tick();
      checkOutput("held reaccept", 32'(busy), 32'd1);
      start = 1'b0;
      lat   = 0;
      while (!done && lat < LIMIT) begin
         tick();
         lat++;
      end
      checkOutput("held second latency", lat, WIDTH);
      checkOutput("held second product", 32'(product), 32'd9);
      tick();

      // Abort in the middle of a run: no done, product cleared.
      a     = 8'd200;
      b     = 8'd200;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      checkOutput("abort running", 32'(busy), 32'd1);
      rst_n = 1'b0;
      tick();
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort product", 32'(product), 32'd0);
      rst_n    = 1'b1;
      doneSeen = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) doneSeen++;
         tick();
      end
      checkOutput("abort no done", doneSeen, 0);
      checkOutput("abort product kept", 32'(product), 32'd0);
      runMult("after abort", 8'd7, 8'd6, 16'd42);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
